// File: rtl/mmio_seg7_display.sv
// Memory-mapped 8-digit seven-segment display controller with DATA/CTRL/FRAME registers.
// Register writes are double-buffered into shadow copies that commit only at frame boundaries.
module mmio_seg7_display #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_4000,
    parameter int          SCAN_DIV  = 100000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_FRAME = 2'd2;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [31:0]      data_reg;
    logic             ctrl_en;
    logic [7:0]       ctrl_dp;
    logic [31:0]      shown_data;
    logic             shown_en;
    logic [7:0]       shown_dp;
    logic             pending;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       digit;
    logic [15:0]      frame_cnt;

    logic [31:0] offset;
    logic [1:0]  reg_idx;
    logic        wr_data;
    logic        wr_ctrl;
    logic        slot_end;
    logic [3:0]  cur_nib;

    // Address decode: word-aligned offsets 0, 4 and 8 only.
    always_comb begin
        offset  = bus_addr - BASE_ADDR;
        reg_idx = offset[3:2];
        bus_hit = bus_cs && (offset <= 32'd8) && (offset[1:0] == 2'b00);
    end

    assign wr_data = bus_hit && bus_we && (reg_idx == REG_DATA);
    assign wr_ctrl = bus_hit && bus_we && (reg_idx == REG_CTRL);

    always_comb begin
        bus_rdata = 32'h0;
        if (bus_hit && !bus_we) begin
            case (reg_idx)
                REG_DATA:  bus_rdata = data_reg;
                REG_CTRL:  bus_rdata = {16'h0, ctrl_dp, 7'h0, ctrl_en};
                REG_FRAME: bus_rdata = {16'h0, frame_cnt};
                default:   bus_rdata = 32'h0;
            endcase
        end
    end

    assign slot_end   = (cnt == CNT_MAX);
    assign frame_tick = slot_end && (digit == 3'd7);

    // Programmed registers; FRAME writes fall through and do nothing.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            data_reg <= 32'h0;
            ctrl_en  <= 1'b1;
            ctrl_dp  <= 8'h00;
        end else begin
            if (wr_data) begin
                data_reg <= bus_wdata;
            end
            if (wr_ctrl) begin
                ctrl_en <= bus_wdata[0];
                ctrl_dp <= bus_wdata[15:8];
            end
        end
    end

    // Shadow commit: takes pre-edge register values; a same-edge write stays pending.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shown_data <= 32'h0;
            shown_en   <= 1'b1;
            shown_dp   <= 8'h00;
            pending    <= 1'b0;
        end else begin
            if (frame_tick && pending) begin
                shown_data <= data_reg;
                shown_en   <= ctrl_en;
                shown_dp   <= ctrl_dp;
            end
            if (wr_data || wr_ctrl) begin
                pending <= 1'b1;
            end else if (frame_tick) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            digit     <= 3'd0;
            frame_cnt <= 16'h0;
        end else begin
            if (slot_end) begin
                cnt   <= '0;
                digit <= digit + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign cur_nib = shown_data[{digit, 2'b00} +: 4];

    always_comb begin
        if (shown_en) begin
            o_sel = ~(8'b1 << digit);
            o_seg = {~shown_dp[digit], hex_to_seg(cur_nib)};
        end else begin
            o_sel = 8'hFF;
            o_seg = 8'hFF;
        end
    end

endmodule

// File: doc/mmio_seg7_display.md
Name: mmio_seg7_display

Overview:
- Memory-mapped 8-digit seven-segment display peripheral on the CPU data bus, alongside DMEM.
- Sits downstream of the CPU: consumes the store/load strobes, ALU-computed address and store data, and drives o_seg/o_sel on the board.
- Holds DATA and CTRL registers and time-multiplexes eight hex digits.
- Updates are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- BASE_ADDR, 32'h1001_4000, byte address of the register block; outside the DMEM window.
- SCAN_DIV, 100000, clk_in cycles per digit slot; must be >= 2.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- bus_cs  input  1  data-bus access strobe (DM_ena equivalent).
- bus_we  input  1  1 = write, 0 = read; only meaningful while bus_cs=1.
- bus_addr  input  32  byte address (CPU alu_out).
- bus_wdata  input  32  store data.
- bus_rdata  output  32  read data; combinational.
- bus_hit  output  1  combinational; 1 when bus_cs=1 and bus_addr is in BASE_ADDR..BASE_ADDR+8 and bus_addr[1:0]=0.
- o_seg  output  8  active-low segments, bit7 = dp, bits6..0 = {g,f,e,d,c,b,a}.
- o_sel  output  8  active-low one-hot digit select; bit0 is the rightmost digit.
- frame_tick  output  1  one-cycle pulse at the end of each 8-digit frame.

Behaviour:
- Register map (word-aligned; a misaligned address gives bus_hit=0, no effect):
  - BASE+0 DATA, R/W: eight hex nibbles; nibble k drives digit k.
  - BASE+4 CTRL, R/W: bit0 EN, bits15:8 DP mask (bit 8+k lights the dp of digit k), other bits read 0.
  - BASE+8 FRAME, RO: bits15:0 frame counter; writes are ignored.
- Writes: when bus_hit & bus_we, the addressed register updates at the clock edge and pending is set.
- Reads: bus_rdata = programmed register value when bus_hit & ~bus_we, otherwise 0. Readback reflects a write on the next cycle, not the shadow copy.
- Shadow registers:
  - shown_data and shown_ctrl drive the display.
  - At a frame boundary with pending=1, they take the DATA/CTRL values held before that edge, and pending clears.
  - If a write lands on the same edge, the new register value is stored and pending stays 1; it commits at the next boundary.
- Scan timing:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - At cnt=SCAN_DIV-1, digit (3 bits) increments, wrapping 7 -> 0.
  - The frame boundary is the edge where digit=7 and cnt=SCAN_DIV-1. frame_tick is high combinationally during that cycle; FRAME increments and wraps 0xFFFF -> 0.
- Output decode:
  - o_sel = ~(8'b1 << digit).
  - o_seg[6:0] = active-low hex pattern of shown_data nibble[digit]:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - o_seg[7] = ~shown_ctrl[8+digit].
- Blanking: when shown_ctrl.EN=0, o_sel=8'hFF and o_seg=8'hFF. The scan counters, FRAME and commits keep running.
- Reset values (asynchronous, immediate on reset=0):
  - DATA=0, CTRL=32'h0000_0001, shadows identical to these, pending=0.
  - cnt=0, digit=0, FRAME=0.
  - Hence o_sel=8'hFE, o_seg=8'hC0, frame_tick=0.
- Reset asserted mid-frame or with a write pending discards the write and restarts the scan from digit 0.
- Outputs change only on clock edges or reset, except bus_rdata, bus_hit and frame_tick, which are combinational.

Test Plan:
- Reset check (SCAN_DIV=4): hold reset=0 -> o_sel=FE, o_seg=C0, bus_rdata at BASE+4 = 0x00000001. Release reset -> o_sel walks FE, FD, FB, ... every 4 cycles; frame_tick pulses on cycle 31, FRAME reads 1.
- Double-buffered write: write DATA=0x12345678 at cycle 5.
  - Next cycle, a read of BASE+0 returns 0x12345678.
  - Digit 0 keeps showing C0 until the frame boundary at cycle 31.
  - In the following frame, digit0 o_seg=80 ('8') and digit1 o_seg=F8 ('7').
- Write on the boundary edge: write DATA=0xFFFFFFFF on the frame_tick cycle -> the display keeps the old value for one more frame; pending commits at the next boundary, then digit0 o_seg=8E.
- CTRL handling:
  - Write CTRL=0x00000100 (EN=0) -> after commit, o_sel=FF and o_seg=FF for a whole frame.
  - Write CTRL=0x00000101 -> after commit, digit0 o_seg bit7=0 and the other digits keep bit7=1.
- Illegal accesses:
  - Write to BASE+8, or to BASE+2 (misaligned) -> registers unchanged; misaligned gives bus_hit=0.
  - Read of BASE+0xC -> bus_hit=0, bus_rdata=0.
- Reset mid-operation: pulse reset low for 1 cycle with a write pending at digit 5 -> all outputs return immediately to reset values, and the pending write is never displayed.
